jtpang_ba_resp: RTL and testbench
=================================

// Module: jtpang_ba_resp
// PURPOSE
// - Responder (SDRAM side) of the 4-bank ba_* read interface and the prog_* load interface used by game cores.
// - Backs each bank with on-chip 16-bit RAM. Arbitrates pending ba_rd requests round-robin.
// - Returns fixed-latency bursts on the shared data_read bus.
// - Used in place of the SDRAM controller for simulation harnesses and small-ROM FPGA test builds.
// PARAMETERS
// - AW     12  per-bank RAM address width (words); ba*_addr[AW-1:0] used, upper bits ignored (wrap)
// - LAT     3  cycles from ba_ack to first data word, 1..15
// - BURST   2  16-bit words per access, 1..4; word k reads addr+k mod 2^AW
// PORTS
// - clk          in   1   system clock
// - rst          in   1   synchronous reset, active-high
// - ba0_addr..ba3_addr  in  22 each  word address per bank, stable while ba_rd[b] high
// - ba_rd        in   4   read request per bank, level, held until ba_ack[b]
// - ba_ack       out  4   one-cycle request-accepted pulse
// - ba_dst       out  4   first data word strobe
// - ba_dok       out  4   data valid strobe, every word
// - ba_rdy       out  4   last data word strobe
// - data_read    out 16   shared read data
// - downloading  in   1   load mode; no new reads accepted while high
// - prog_addr    in  22   load word address
// - prog_data    in  16   load data
// - prog_mask    in   2   byte mask, bit=1 byte NOT written ([1]=upper)
// - prog_ba      in   2   load bank
// - prog_we      in   1   load write strobe
// - prog_rdy     out  1   one-cycle write-done pulse
// - ba0_din      in  16   bank-0 write data (only with JTPANG_BARESP_WR_EN)
// - ba0_din_m    in   2   bank-0 write mask, same polarity as prog_mask
// - ba_wr        in   1   bank-0 write qualifier for ba_rd[0]
// BEHAVIOUR
// - Reset: all strobes 0, data_read=0, state IDLE, round-robin pointer=bank0. RAM contents are not cleared.
// - FSM states: IDLE, ACK, WAIT, BURST.
// - IDLE
//   - Sampled only when downloading=0.
//   - Picks the lowest pending bank at or after rr_ptr (wrap 3->0).
//   - Latches bank and address[AW-1:0], then goes to ACK.
// - ACK: ba_ack[sel]=1 for exactly 1 cycle; load WAIT counter with LAT-1.
// - WAIT: count down to 0, then go to BURST.
// - BURST: one word per cycle, BURST words total.
//   - data_read and ba_dok[sel] registered together.
//   - ba_dst[sel] on word 0; ba_rdy[sel] on word BURST-1 (both on the same cycle if BURST=1).
// - Latency: rd seen at cycle t -> ack at t+1 -> first word at t+1+LAT -> rdy at t+LAT+BURST.
// - After the last word: rr_ptr=sel+1; return to IDLE. A still-high ba_rd is a new request (earliest ack at rdy+2).
// - ba_rd[sel] changes after ack are ignored until rdy. Other banks stay pending, never dropped.
// - Only one access in flight; strobes are one-hot across banks; data_read holds its last value between bursts.
// - prog_we:
//   - Writes RAM[prog_ba][prog_addr[AW-1:0]] with per-byte mask, whatever the FSM state.
//   - prog_rdy pulses the next cycle.
//   - Back-to-back writes are allowed, one per cycle.
//   - Same address as an in-flight burst word in the same cycle: the read returns the old data.
// - downloading rising mid-access: the current burst completes normally; new picks are blocked until it falls.
// - rst mid-burst: outputs go to 0 next edge; the pending burst is abandoned, no rdy issued.
// CONFIGURATION
// - JTPANG_BARESP_WR_EN defined:
//   - ba_rd[0]&ba_wr is a write access.
//   - At ACK, writes ba0_din with ba0_din_m to the latched address.
//   - ack, then rdy+dok (no dst) at t+2; no burst; data_read unchanged.
// - JTPANG_BARESP_WR_EN undefined:
//   - ba_wr, ba0_din and ba0_din_m are ignored.
//   - Every access is a read; the bank-0 write logic is absent from the netlist.
// TESTING
// - Load bank1 @0x10=0x1234, @0x11=0xABCD (mask 00); rd bank1 addr 0x10 at t -> ack t+1, dst+dok 0x1234 @t+4, rdy+dok 0xABCD @t+5 (LAT3,BURST2).
// - prog_mask=2'b10, data 0xFFFF over 0x1234 -> reads 0x12FF; prog_rdy exactly 1 cycle after each we.
// - ba_rd=4'b1011 held continuously -> service order 0,1,3,0,1,3; every ack followed by exactly one rdy on the same bank.
// - Addr 0x3FFFFF, AW=12 -> reads RAM[0xFFF] then RAM[0x000].
// - downloading=1 with ba_rd[2] high -> no ack; ack 1 cycle after downloading falls; rst asserted during WAIT -> all outputs 0, no rdy.
// - WR_EN: ba_wr=1, din 0x5A5A to bank0 @7 -> ack t+1, rdy t+2; later read @7 returns 0x5A5A.

Source files
------------

// File: rtl/jtpang_ba_resp_if.sv
// Bus bundle between a game core (master) and the on-chip ba_*/prog_* responder (slave).
// Holds the four bank read ports, the shared read-data return, the ROM-load port and the optional bank-0 write port.
interface jtpang_ba_resp_if;
    logic [21:0] ba0_addr;
    logic [21:0] ba1_addr;
    logic [21:0] ba2_addr;
    logic [21:0] ba3_addr;
    logic [3:0]  ba_rd;
    logic [3:0]  ba_ack;
    logic [3:0]  ba_dst;
    logic [3:0]  ba_dok;
    logic [3:0]  ba_rdy;
    logic [15:0] data_read;
    logic        downloading;
    logic [21:0] prog_addr;
    logic [15:0] prog_data;
    logic [1:0]  prog_mask;
    logic [1:0]  prog_ba;
    logic        prog_we;
    logic        prog_rdy;
    logic [15:0] ba0_din;
    logic [1:0]  ba0_din_m;
    logic        ba_wr;

    modport master (
        output ba0_addr, ba1_addr, ba2_addr, ba3_addr, ba_rd,
        output downloading, prog_addr, prog_data, prog_mask, prog_ba, prog_we,
        output ba0_din, ba0_din_m, ba_wr,
        input  ba_ack, ba_dst, ba_dok, ba_rdy, data_read, prog_rdy
    );

    modport slave (
        input  ba0_addr, ba1_addr, ba2_addr, ba3_addr, ba_rd,
        input  downloading, prog_addr, prog_data, prog_mask, prog_ba, prog_we,
        input  ba0_din, ba0_din_m, ba_wr,
        output ba_ack, ba_dst, ba_dok, ba_rdy, data_read, prog_rdy
    );
endinterface

// File: rtl/jtpang_ba_resp.sv
// On-chip RAM stand-in for the SDRAM controller: round-robin ba_rd arbiter, fixed-latency bursts, prog_* loader.
// Optional bank-0 write access is enabled by defining JTPANG_BARESP_WR_EN.
module jtpang_ba_resp #(
    parameter int AW    = 12,
    parameter int LAT   = 3,
    parameter int BURST = 2
) (
    input  logic              clk,
    input  logic              rst,
    jtpang_ba_resp_if.slave   bus
);
    localparam int         DEPTH   = 4 << AW;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACK   = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_BURST = 2'd3;
    localparam logic [2:0] BURST_W = 3'(BURST);
    localparam logic [3:0] LAT_M1  = 4'(LAT - 1);

    logic [1:0]    r_state;
    logic [1:0]    r_rr;
    logic [1:0]    r_sel;
    logic [AW-1:0] r_addr;
    logic [3:0]    r_cnt;
    logic [2:0]    r_widx;
    logic [3:0]    r_ack;
    logic [3:0]    r_dst;
    logic [3:0]    r_dok;
    logic [3:0]    r_rdy;
    logic [15:0]   r_data;
    logic          r_prog_rdy;
    logic [15:0]   r_mem [0:DEPTH-1];

    logic [2:0]    w_pick;
    logic          w_go;
    logic [AW-1:0] w_req_addr;
    logic [3:0]    w_sel_oh;
    logic [AW-1:0] w_rd_addr;
    logic [15:0]   w_rdata;
    logic          w_emit;
    logic          w_last;
    logic          w_wr_acc;
    logic [AW+1:0] w_prog_idx;

    // {found, bank}: first requesting bank scanning upward from ptr with wrap.
    function automatic logic [2:0] f_pick(input logic [3:0] req, input logic [1:0] ptr);
        logic [2:0] res;
        logic [1:0] b;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            b = ptr + 2'(i);
            if (req[b]) res = {1'b1, b};
        end
        return res;
    endfunction

    assign w_pick = f_pick(bus.ba_rd, r_rr);
    assign w_go   = (r_state == S_IDLE) && !bus.downloading && w_pick[2];

    always_comb begin
        w_req_addr = bus.ba0_addr[AW-1:0];
        case (w_pick[1:0])
            2'd1:    w_req_addr = bus.ba1_addr[AW-1:0];
            2'd2:    w_req_addr = bus.ba2_addr[AW-1:0];
            2'd3:    w_req_addr = bus.ba3_addr[AW-1:0];
            default: w_req_addr = bus.ba0_addr[AW-1:0];
        endcase
    end

    assign w_sel_oh   = 4'b0001 << r_sel;
    assign w_rd_addr  = r_addr + AW'(r_widx);
    assign w_rdata    = r_mem[{r_sel, w_rd_addr}];
    assign w_last     = (r_widx == BURST_W - 3'd1);
    assign w_prog_idx = {bus.prog_ba, bus.prog_addr[AW-1:0]};

    // A word leaves on the edge that ends the wait period, then one per cycle until BURST are out.
    assign w_emit = !w_wr_acc &&
                    (((r_state == S_ACK) && (LAT == 1)) ||
                     ((r_state == S_WAIT) && (r_cnt == 4'd1)) ||
                     ((r_state == S_BURST) && (r_widx != BURST_W)));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_rr    <= 2'd0;
            r_cnt   <= 4'd0;
            r_widx  <= 3'd0;
            r_ack   <= 4'd0;
            r_dst   <= 4'd0;
            r_dok   <= 4'd0;
            r_rdy   <= 4'd0;
            r_data  <= 16'd0;
        end else begin
            r_ack <= 4'd0;
            r_dst <= 4'd0;
            r_dok <= 4'd0;
            r_rdy <= 4'd0;
            if (w_emit) begin
                r_data <= w_rdata;
                r_dok  <= w_sel_oh;
                r_dst  <= (r_widx == 3'd0) ? w_sel_oh : 4'd0;
                r_rdy  <= w_last ? w_sel_oh : 4'd0;
                r_widx <= r_widx + 3'd1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_go) begin
                        r_ack   <= 4'b0001 << w_pick[1:0];
                        r_widx  <= 3'd0;
                        r_state <= S_ACK;
                    end
                end
                S_ACK: begin
                    if (w_wr_acc) begin
                        // Write access completes here: dok+rdy, no dst, data_read untouched.
                        r_dok   <= w_sel_oh;
                        r_rdy   <= w_sel_oh;
                        r_widx  <= BURST_W;
                        r_state <= S_BURST;
                    end else if (LAT == 1) begin
                        r_state <= S_BURST;
                    end else begin
                        r_cnt   <= LAT_M1;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd1) r_state <= S_BURST;
                    else               r_cnt   <= r_cnt - 4'd1;
                end
                S_BURST: begin
                    if (r_widx == BURST_W) begin
                        r_rr    <= r_sel + 2'd1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_go) begin
            r_sel  <= w_pick[1:0];
            r_addr <= w_req_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_prog_rdy <= 1'b0;
        else     r_prog_rdy <= bus.prog_we;
    end

`ifdef JTPANG_BARESP_WR_EN
    logic r_wr;

    always_ff @(posedge clk) begin
        if (rst)       r_wr <= 1'b0;
        else if (w_go) r_wr <= (w_pick[1:0] == 2'd0) && bus.ba_wr;
    end

    assign w_wr_acc = (r_state == S_ACK) && r_wr;
`else
    logic w_unused_wr;
    assign w_unused_wr = ^{bus.ba_wr, bus.ba0_din, bus.ba0_din_m};
    assign w_wr_acc    = 1'b0;
`endif

    // Reads sample the array combinationally, so a write on the same edge is seen only by later reads.
    always_ff @(posedge clk) begin
`ifdef JTPANG_BARESP_WR_EN
        if (w_wr_acc) begin
            if (!bus.ba0_din_m[0]) r_mem[{2'd0, r_addr}][7:0]  <= bus.ba0_din[7:0];
            if (!bus.ba0_din_m[1]) r_mem[{2'd0, r_addr}][15:8] <= bus.ba0_din[15:8];
        end
`endif
        if (bus.prog_we) begin
            if (!bus.prog_mask[0]) r_mem[w_prog_idx][7:0]  <= bus.prog_data[7:0];
            if (!bus.prog_mask[1]) r_mem[w_prog_idx][15:8] <= bus.prog_data[15:8];
        end
    end

    logic w_unused_addr;
    assign w_unused_addr = ^{bus.ba0_addr[21:AW], bus.ba1_addr[21:AW], bus.ba2_addr[21:AW],
                             bus.ba3_addr[21:AW], bus.prog_addr[21:AW]};

    assign bus.ba_ack    = r_ack;
    assign bus.ba_dst    = r_dst;
    assign bus.ba_dok    = r_dok;
    assign bus.ba_rdy    = r_rdy;
    assign bus.data_read = r_data;
    assign bus.prog_rdy  = r_prog_rdy;
endmodule

// File: tb/tb_jtpang_ba_resp.sv
// Randomized self-checking bench for jtpang_ba_resp against a word-array model of the four banks.
// Timing expectations come from the documented latency rules (ack t+1, first word t+1+LAT, rdy t+LAT+BURST).
module tb_jtpang_ba_resp;
    localparam int AW    = 12;
    localparam int LAT   = 3;
    localparam int BURST = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    jtpang_ba_resp_if bus();

    jtpang_ba_resp #(.AW(AW), .LAT(LAT), .BURST(BURST)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] mdl [4][1<<AW];

    int          cap_ack, cap_dst, cap_rdy, cap_nw;
    logic [15:0] cap_w [8];
    bit          cap_stray;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input int b, input logic [21:0] a);
        case (b)
            0: bus.ba0_addr = a;
            1: bus.ba1_addr = a;
            2: bus.ba2_addr = a;
            default: bus.ba3_addr = a;
        endcase
    endtask

    function automatic logic [15:0] mdl_rd(input int b, input logic [21:0] a, input int k);
        logic [AW-1:0] ix;
        ix = a[AW-1:0] + AW'(k);
        return mdl[b][ix];
    endfunction

    // Single load write; model applies the byte mask (bit=1 keeps the old byte).
    task automatic prog_wr(input int b, input logic [21:0] a, input logic [15:0] d, input logic [1:0] m);
        logic [AW-1:0] ix;
        logic [15:0]   old;
        bus.prog_ba   = 2'(b);
        bus.prog_addr = a;
        bus.prog_data = d;
        bus.prog_mask = m;
        bus.prog_we   = 1'b1;
        tick();
        bus.prog_we   = 1'b0;
        ix  = a[AW-1:0];
        old = mdl[b][ix];
        mdl[b][ix] = {m[1] ? old[15:8] : d[15:8], m[0] ? old[7:0] : d[7:0]};
    endtask

    // Issues one request from an idle responder and records what comes back (no checking here).
    task automatic run_read(input int b, input logic [21:0] a);
        cap_ack = -1; cap_dst = -1; cap_rdy = -1; cap_nw = 0; cap_stray = 0;
        set_addr(b, a);
        bus.ba_rd[b] = 1'b1;
        for (int c = 1; c <= 40 && cap_rdy < 0; c++) begin
            tick();
            if (((bus.ba_ack | bus.ba_dst | bus.ba_dok | bus.ba_rdy) & ~(4'b0001 << b)) != 4'd0)
                cap_stray = 1;
            if (bus.ba_ack[b]) begin
                if (cap_ack < 0) cap_ack = c;
                bus.ba_rd[b] = 1'b0;
            end
            if (bus.ba_dst[b] && cap_dst < 0) cap_dst = c;
            if (bus.ba_dok[b]) begin
                if (cap_nw < 8) cap_w[cap_nw] = bus.data_read;
                cap_nw++;
            end
            if (bus.ba_rdy[b]) cap_rdy = c;
        end
        bus.ba_rd[b] = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick(); tick();
        n_cmp++;
        if ({bus.ba_ack, bus.ba_dst, bus.ba_dok, bus.ba_rdy} !== 16'h0) begin
            n_err++; $display("FAIL reset_strobes: got %h want 0000", {bus.ba_ack, bus.ba_dst, bus.ba_dok, bus.ba_rdy});
        end
        n_cmp++;
        if (bus.data_read !== 16'h0) begin n_err++; $display("FAIL reset_data: got %h want 0000", bus.data_read); end
        n_cmp++;
        if (bus.prog_rdy !== 1'b0) begin n_err++; $display("FAIL reset_prog_rdy: got %b want 0", bus.prog_rdy); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_load_read();
        prog_wr(1, 22'h10, 16'h1234, 2'b00);
        n_cmp++;
        if (bus.prog_rdy !== 1'b1) begin n_err++; $display("FAIL load_prog_rdy: got %b want 1", bus.prog_rdy); end
        prog_wr(1, 22'h11, 16'hABCD, 2'b00);
        tick();
        run_read(1, 22'h10);
        n_cmp++;
        if (cap_ack !== 1) begin n_err++; $display("FAIL load_ack_cycle: got %0d want 1", cap_ack); end
        n_cmp++;
        if (cap_dst !== LAT + 1) begin n_err++; $display("FAIL load_dst_cycle: got %0d want %0d", cap_dst, LAT + 1); end
        n_cmp++;
        if (cap_rdy !== LAT + BURST) begin n_err++; $display("FAIL load_rdy_cycle: got %0d want %0d", cap_rdy, LAT + BURST); end
        n_cmp++;
        if (cap_nw !== BURST) begin n_err++; $display("FAIL load_words: got %0d want %0d", cap_nw, BURST); end
        n_cmp++;
        if (cap_w[0] !== 16'h1234) begin n_err++; $display("FAIL load_word0: got %h want 1234", cap_w[0]); end
        n_cmp++;
        if (cap_w[1] !== 16'hABCD) begin n_err++; $display("FAIL load_word1: got %h want abcd", cap_w[1]); end
        n_cmp++;
        if (cap_stray !== 1'b0) begin n_err++; $display("FAIL load_onehot: got %b want 0", cap_stray); end
        tick(); tick();
        n_cmp++;
        if (bus.data_read !== 16'hABCD) begin n_err++; $display("FAIL load_hold: got %h want abcd", bus.data_read); end
    endtask

    task automatic test_mask();
        prog_wr(1, 22'h10, 16'hFFFF, 2'b10);
        n_cmp++;
        if (bus.prog_rdy !== 1'b1) begin n_err++; $display("FAIL mask_prog_rdy: got %b want 1", bus.prog_rdy); end
        tick();
        n_cmp++;
        if (bus.prog_rdy !== 1'b0) begin n_err++; $display("FAIL mask_prog_rdy_clr: got %b want 0", bus.prog_rdy); end
        run_read(1, 22'h10);
        n_cmp++;
        if (cap_w[0] !== 16'h12FF) begin n_err++; $display("FAIL mask_word0: got %h want 12ff", cap_w[0]); end
        n_cmp++;
        if (cap_w[1] !== mdl_rd(1, 22'h10, 1)) begin n_err++; $display("FAIL mask_word1: got %h want %h", cap_w[1], mdl_rd(1, 22'h10, 1)); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] d;
        logic [AW-1:0] ix;
        for (int i = 0; i < 3; i++) begin
            d = 16'($urandom);
            ix = AW'(12'h20 + i);
            bus.prog_ba = 2'd3; bus.prog_addr = 22'(ix); bus.prog_data = d; bus.prog_mask = 2'b00;
            bus.prog_we = 1'b1;
            tick();
            mdl[3][ix] = d;
            n_cmp++;
            if (bus.prog_rdy !== 1'b1) begin n_err++; $display("FAIL b2b_prog_rdy%0d: got %b want 1", i, bus.prog_rdy); end
        end
        bus.prog_we = 1'b0;
        tick();
        n_cmp++;
        if (bus.prog_rdy !== 1'b0) begin n_err++; $display("FAIL b2b_prog_rdy_end: got %b want 0", bus.prog_rdy); end
        for (int i = 0; i < 2; i++) begin
            run_read(3, 22'(12'h20 + i));
            for (int k = 0; k < BURST; k++) begin
                n_cmp++;
                if (cap_w[k] !== mdl_rd(3, 22'(12'h20 + i), k)) begin
                    n_err++; $display("FAIL b2b_word%0d_%0d: got %h want %h", i, k, cap_w[k], mdl_rd(3, 22'(12'h20 + i), k));
                end
            end
        end
    endtask

    task automatic test_wrap();
        prog_wr(2, 22'hFFF, 16'hC0DE, 2'b00);
        prog_wr(2, 22'h000, 16'hBEEF, 2'b00);
        run_read(2, 22'h3FFFFF);
        n_cmp++;
        if (cap_w[0] !== 16'hC0DE) begin n_err++; $display("FAIL wrap_word0: got %h want c0de", cap_w[0]); end
        n_cmp++;
        if (cap_w[1] !== 16'hBEEF) begin n_err++; $display("FAIL wrap_word1: got %h want beef", cap_w[1]); end
        n_cmp++;
        if (cap_rdy !== LAT + BURST) begin n_err++; $display("FAIL wrap_rdy_cycle: got %0d want %0d", cap_rdy, LAT + BURST); end
    endtask

    task automatic test_random();
        int b;
        logic [21:0] a;
        for (int it = 0; it < 16; it++) begin
            b = $urandom_range(0, 3);
            a = 22'($urandom);
            for (int k = 0; k < BURST; k++) prog_wr(b, a + 22'(k), 16'($urandom), 2'b00);
            prog_wr(b, a + 22'($urandom_range(0, BURST - 1)), 16'($urandom), 2'($urandom_range(0, 3)));
            run_read(b, a);
            n_cmp++;
            if (cap_ack !== 1 || cap_dst !== LAT + 1 || cap_rdy !== LAT + BURST) begin
                n_err++; $display("FAIL rand_timing%0d: got ack %0d dst %0d rdy %0d want 1 %0d %0d", it, cap_ack, cap_dst, cap_rdy, LAT + 1, LAT + BURST);
            end
            n_cmp++;
            if (cap_nw !== BURST || cap_stray !== 1'b0) begin
                n_err++; $display("FAIL rand_shape%0d: got words %0d stray %b want %0d 0", it, cap_nw, cap_stray, BURST);
            end
            for (int k = 0; k < BURST; k++) begin
                n_cmp++;
                if (cap_w[k] !== mdl_rd(b, a, k)) begin
                    n_err++; $display("FAIL rand_word%0d_%0d: got %h want %h", it, k, cap_w[k], mdl_rd(b, a, k));
                end
            end
        end
    endtask

    task automatic test_collision();
        logic [15:0] w0;
        bit seen;
        prog_wr(3, 22'h100, 16'h1111, 2'b00);
        prog_wr(3, 22'h101, 16'h2222, 2'b00);
        set_addr(3, 22'h100);
        bus.ba_rd[3] = 1'b1;
        seen = 0; w0 = 16'h0;
        for (int c = 1; c <= 30 && !seen; c++) begin
            tick();
            if (bus.ba_ack[3]) bus.ba_rd[3] = 1'b0;
            if (c == LAT + 1) begin
                bus.prog_we = 1'b0;
                w0 = bus.data_read;
            end
            if (c == LAT) begin
                bus.prog_ba = 2'd3; bus.prog_addr = 22'h100; bus.prog_data = 16'h9999; bus.prog_mask = 2'b00;
                bus.prog_we = 1'b1;
            end
            if (bus.ba_rdy[3]) seen = 1;
        end
        bus.prog_we = 1'b0;
        bus.ba_rd[3] = 1'b0;
        tick();
        mdl[3][12'h100] = 16'h9999;
        n_cmp++;
        if (w0 !== 16'h1111) begin n_err++; $display("FAIL collide_old: got %h want 1111", w0); end
        run_read(3, 22'h100);
        n_cmp++;
        if (cap_w[0] !== 16'h9999) begin n_err++; $display("FAIL collide_new: got %h want 9999", cap_w[0]); end
    endtask

    task automatic test_round_robin();
        int order [6];
        int exp_o [6] = '{0, 1, 3, 0, 1, 3};
        logic [21:0] ra [4];
        int n_ack, n_rdy, cur, widx, last_rdy, errs, bank;
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        ra[0] = 22'h040; ra[1] = 22'h050; ra[2] = 22'h0; ra[3] = 22'h060;
        for (int b = 0; b < 4; b++) begin
            if (b != 2) begin
                for (int k = 0; k < BURST; k++) prog_wr(b, ra[b] + 22'(k), 16'($urandom), 2'b00);
                set_addr(b, ra[b]);
            end
        end
        n_ack = 0; n_rdy = 0; cur = -1; widx = 0; last_rdy = -100; errs = 0;
        for (int i = 0; i < 6; i++) order[i] = -1;
        bus.ba_rd = 4'b1011;
        for (int c = 1; c <= 300 && n_rdy < 6; c++) begin
            tick();
            if (bus.ba_ack != 4'd0) begin
                bank = 0;
                for (int i = 0; i < 4; i++) if (bus.ba_ack[i]) bank = i;
                if ($countones(bus.ba_ack) != 1 || cur >= 0) errs++;
                if (n_ack < 6) order[n_ack] = bank;
                if (n_ack > 0) begin
                    n_cmp++;
                    if (c - last_rdy !== 2) begin n_err++; $display("FAIL rr_gap%0d: got %0d want 2", n_ack, c - last_rdy); end
                end
                n_ack++; cur = bank; widx = 0;
            end
            if (bus.ba_dok != 4'd0) begin
                if (cur < 0 || bus.ba_dok != (4'b0001 << cur)) errs++;
                else begin
                    n_cmp++;
                    if (bus.data_read !== mdl_rd(cur, ra[cur], widx)) begin
                        n_err++; $display("FAIL rr_data b%0d w%0d: got %h want %h", cur, widx, bus.data_read, mdl_rd(cur, ra[cur], widx));
                    end
                    widx++;
                end
            end
            if (bus.ba_rdy != 4'd0) begin
                if (cur < 0 || bus.ba_rdy != (4'b0001 << cur) || widx != BURST) errs++;
                n_rdy++; last_rdy = c; cur = -1;
            end
        end
        bus.ba_rd = 4'b0000;
        tick(); tick(); tick();
        n_cmp++;
        if (n_rdy !== 6) begin n_err++; $display("FAIL rr_count: got %0d want 6", n_rdy); end
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (order[i] !== exp_o[i]) begin n_err++; $display("FAIL rr_order%0d: got %0d want %0d", i, order[i], exp_o[i]); end
        end
        n_cmp++;
        if (errs !== 0) begin n_err++; $display("FAIL rr_pairing: got %0d errors want 0", errs); end
    endtask

    task automatic test_download();
        int acks, rdy0, ack1, words;
        bit done;
        prog_wr(2, 22'h200, 16'h2A2A, 2'b00);
        prog_wr(2, 22'h201, 16'h2B2B, 2'b00);
        set_addr(2, 22'h200);
        bus.downloading = 1'b1;
        bus.ba_rd[2] = 1'b1;
        acks = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (bus.ba_ack != 4'd0) acks++;
        end
        n_cmp++;
        if (acks !== 0) begin n_err++; $display("FAIL dl_blocked: got %0d acks want 0", acks); end
        bus.downloading = 1'b0;
        tick();
        n_cmp++;
        if (bus.ba_ack !== 4'b0100) begin n_err++; $display("FAIL dl_release_ack: got %b want 0100", bus.ba_ack); end
        bus.ba_rd[2] = 1'b0;
        done = 0;
        for (int c = 0; c < 20 && !done; c++) begin
            tick();
            if (bus.ba_rdy[2]) done = 1;
        end
        tick();
        n_cmp++;
        if (done !== 1'b1) begin n_err++; $display("FAIL dl_release_rdy: got %b want 1", done); end

        // downloading rises after ack: the burst must still finish, the other bank must wait.
        set_addr(0, 22'h040);
        set_addr(1, 22'h050);
        bus.ba_rd[0] = 1'b1;
        tick();
        bus.ba_rd[0] = 1'b0;
        bus.downloading = 1'b1;
        bus.ba_rd[1] = 1'b1;
        rdy0 = 0; ack1 = 0; words = 0;
        for (int c = 0; c < LAT + BURST + 8; c++) begin
            tick();
            if (bus.ba_dok[0]) begin
                n_cmp++;
                if (bus.data_read !== mdl_rd(0, 22'h040, words)) begin
                    n_err++; $display("FAIL dl_mid_word%0d: got %h want %h", words, bus.data_read, mdl_rd(0, 22'h040, words));
                end
                words++;
            end
            if (bus.ba_rdy[0]) rdy0++;
            if (bus.ba_ack[1]) ack1++;
        end
        n_cmp++;
        if (rdy0 !== 1 || words !== BURST) begin n_err++; $display("FAIL dl_mid_complete: got rdy %0d words %0d want 1 %0d", rdy0, words, BURST); end
        n_cmp++;
        if (ack1 !== 0) begin n_err++; $display("FAIL dl_mid_blocked: got %0d acks want 0", ack1); end
        bus.downloading = 1'b0;
        tick();
        n_cmp++;
        if (bus.ba_ack !== 4'b0010) begin n_err++; $display("FAIL dl_mid_release: got %b want 0010", bus.ba_ack); end
        bus.ba_rd[1] = 1'b0;
        done = 0;
        for (int c = 0; c < 20 && !done; c++) begin
            tick();
            if (bus.ba_rdy[1]) done = 1;
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int strobes;
        set_addr(1, 22'h10);
        bus.ba_rd[1] = 1'b1;
        tick();
        n_cmp++;
        if (bus.ba_ack !== 4'b0010) begin n_err++; $display("FAIL rstmid_ack: got %b want 0010", bus.ba_ack); end
        bus.ba_rd[1] = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        n_cmp++;
        if ({bus.ba_ack, bus.ba_dst, bus.ba_dok, bus.ba_rdy, bus.data_read, bus.prog_rdy} !== 33'h0) begin
            n_err++; $display("FAIL rstmid_outputs: got %h %h want 0", {bus.ba_ack, bus.ba_dst, bus.ba_dok, bus.ba_rdy}, bus.data_read);
        end
        rst = 1'b0;
        strobes = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if ({bus.ba_ack, bus.ba_dst, bus.ba_dok, bus.ba_rdy} != 16'h0) strobes++;
        end
        n_cmp++;
        if (strobes !== 0) begin n_err++; $display("FAIL rstmid_abandon: got %0d strobe cycles want 0", strobes); end
        run_read(1, 22'h10);
        n_cmp++;
        if (cap_ack !== 1 || cap_w[0] !== mdl_rd(1, 22'h10, 0)) begin
            n_err++; $display("FAIL rstmid_recover: got ack %0d data %h want 1 %h", cap_ack, cap_w[0], mdl_rd(1, 22'h10, 0));
        end
    endtask

    task automatic test_wr_qual();
`ifdef JTPANG_BARESP_WR_EN
        logic [15:0] pre;
        pre = bus.data_read;
        bus.ba0_din = 16'h5A5A;
        bus.ba0_din_m = 2'b00;
        bus.ba_wr = 1'b1;
        run_read(0, 22'h7);
        bus.ba_wr = 1'b0;
        mdl[0][12'h7] = 16'h5A5A;
        n_cmp++;
        if (cap_ack !== 1 || cap_rdy !== 2) begin n_err++; $display("FAIL wr_timing: got ack %0d rdy %0d want 1 2", cap_ack, cap_rdy); end
        n_cmp++;
        if (cap_dst !== -1 || cap_nw !== 1) begin n_err++; $display("FAIL wr_shape: got dst %0d doks %0d want -1 1", cap_dst, cap_nw); end
        n_cmp++;
        if (cap_w[0] !== pre) begin n_err++; $display("FAIL wr_data_hold: got %h want %h", cap_w[0], pre); end
        run_read(0, 22'h7);
        n_cmp++;
        if (cap_w[0] !== 16'h5A5A) begin n_err++; $display("FAIL wr_readback: got %h want 5a5a", cap_w[0]); end
`else
        prog_wr(0, 22'h30, 16'h3C3C, 2'b00);
        prog_wr(0, 22'h31, 16'h4D4D, 2'b00);
        bus.ba0_din = 16'hDEAD;
        bus.ba0_din_m = 2'b00;
        bus.ba_wr = 1'b1;
        run_read(0, 22'h30);
        bus.ba_wr = 1'b0;
        n_cmp++;
        if (cap_dst !== LAT + 1 || cap_rdy !== LAT + BURST) begin
            n_err++; $display("FAIL wrq_timing: got dst %0d rdy %0d want %0d %0d", cap_dst, cap_rdy, LAT + 1, LAT + BURST);
        end
        n_cmp++;
        if (cap_w[0] !== 16'h3C3C || cap_w[1] !== 16'h4D4D) begin
            n_err++; $display("FAIL wrq_data: got %h %h want 3c3c 4d4d", cap_w[0], cap_w[1]);
        end
        run_read(0, 22'h30);
        n_cmp++;
        if (cap_w[0] !== 16'h3C3C) begin n_err++; $display("FAIL wrq_unwritten: got %h want 3c3c", cap_w[0]); end
`endif
    endtask

    initial begin
        bus.ba0_addr = '0; bus.ba1_addr = '0; bus.ba2_addr = '0; bus.ba3_addr = '0;
        bus.ba_rd = 4'd0;
        bus.downloading = 1'b0;
        bus.prog_addr = '0; bus.prog_data = '0; bus.prog_mask = 2'b00; bus.prog_ba = 2'd0; bus.prog_we = 1'b0;
        bus.ba0_din = '0; bus.ba0_din_m = 2'b00; bus.ba_wr = 1'b0;
        test_reset();
        test_load_read();
        test_mask();
        test_back_to_back();
        test_wrap();
        test_random();
        test_collision();
        test_round_robin();
        test_download();
        test_reset_mid();
        test_wr_qual();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
